// File: rtl/multi_gen_pkg.sv
// multi_gen_pkg: shared constants and helpers for the multi_gen_1 multiplier.
//   - Legal-range constants for LATENCY and FRAC_BITS.
//   - sat_bounds(): signed min/max representable in a given width, returned
//     in a 65-bit container wide enough for the 2*WIDTH+1 rounding sum.
package multi_gen_pkg;

    localparam int LATENCY_MIN   = 1;
    localparam int LATENCY_MAX   = 8;
    localparam int FRAC_BITS_MIN = 0;
    // FRAC_BITS is also limited by WIDTH; 32 is the widest legal WIDTH.
    localparam int FRAC_BITS_MAX = 32;

    localparam int BOUND_W = 65;

    typedef struct packed {
        logic signed [BOUND_W-1:0] max_v;
        logic signed [BOUND_W-1:0] min_v;
    } sat_bounds_t;

    function automatic sat_bounds_t sat_bounds(input int w);
        sat_bounds_t b;
        b.max_v = (BOUND_W'(1) << (w - 1)) - BOUND_W'(1);
        b.min_v = -(BOUND_W'(1) << (w - 1));
        return b;
    endfunction

endpackage

// File: rtl/multi_pipe_stage.sv
// multi_pipe_stage: one data+valid pipeline register.
// Ports:
//   CLK, RST_N        clock, async active-low reset (clears valid and data)
//   ce_i              advance enable; 0 holds valid and data
//   flush_i           clears valid at the next edge regardless of ce_i
//   valid_i, data_i   incoming sample
//   valid_o, data_o   registered sample
// Data only loads for a valid, non-flushed sample so it holds its last
// value while the stage carries a bubble.
module multi_pipe_stage
    import multi_gen_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          ce_i,
    input  logic          flush_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (ce_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/multi_gen_1.sv
// multi_gen_1: pipelined signed multiplier with round-half-up fixed-point
// scaling and overflow detection.
// Ports:
//   CLK, RST_N     clock, async active-low reset
//   CE             pipeline advance enable (0 stalls everything)
//   FLUSH          synchronous invalidate of all in-flight samples
//   IN_VALID, A, B signed operands, WIDTH bits each
//   OUT_VALID      P/OVF carry a new result
//   P              scaled result, OUT_WIDTH bits (holds when OUT_VALID=0)
//   OVF            scaled value fell outside the OUT_WIDTH signed range
// Build option: define MULTI_GEN_SAT_EN to clamp P on overflow; otherwise P
// wraps to the low OUT_WIDTH bits.
// Stage 1 registers the full product, middle stages delay it, and the last
// stage registers the rounded/shifted/clamped result. LATENCY=1 collapses
// everything into the single output stage.
module multi_gen_1
    import multi_gen_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 32,
    parameter int FRAC_BITS = 0,
    parameter int LATENCY   = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CE,
    input  logic                 FLUSH,
    input  logic                 IN_VALID,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 OUT_VALID,
    output logic [OUT_WIDTH-1:0] P,
    output logic                 OVF
);

    localparam int LAT  = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                          (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
    localparam int FRAC = (FRAC_BITS < FRAC_BITS_MIN) ? FRAC_BITS_MIN :
                          (FRAC_BITS > FRAC_BITS_MAX) ? FRAC_BITS_MAX : FRAC_BITS;
    localparam int PW   = 2 * WIDTH;
    localparam int SW   = PW + 1;

    localparam sat_bounds_t               BOUNDS  = sat_bounds(OUT_WIDTH);
    localparam logic signed [BOUND_W-1:0] OUT_MAX = BOUNDS.max_v;
    localparam logic signed [BOUND_W-1:0] OUT_MIN = BOUNDS.min_v;
    // 2^(FRAC-1), or 0 when FRAC=0 (the shift-then-halve avoids a -1 shift).
    localparam logic [SW-1:0]             RND     = (SW'(1) << FRAC) >> 1;

    logic [PW-1:0] a_ext, b_ext, prod;
    logic [PW-1:0] mul_data;
    logic          mul_valid;

    // Sign-extended operands: low PW bits of the unsigned product equal the
    // exact signed product.
    assign a_ext = {{WIDTH{A[WIDTH-1]}}, A};
    assign b_ext = {{WIDTH{B[WIDTH-1]}}, B};
    assign prod  = a_ext * b_ext;

    generate
        if (LAT == 1) begin : g_single
            assign mul_data  = prod;
            assign mul_valid = IN_VALID;
        end else begin : g_multi
            logic [PW-1:0] pd [LAT-1];
            logic          pv [LAT-1];

            multi_pipe_stage #(.DW(PW)) u_mul (
                .CLK     (CLK),
                .RST_N   (RST_N),
                .ce_i    (CE),
                .flush_i (FLUSH),
                .valid_i (IN_VALID),
                .data_i  (prod),
                .valid_o (pv[0]),
                .data_o  (pd[0])
            );

            for (genvar i = 1; i < LAT - 1; i++) begin : g_delay
                multi_pipe_stage #(.DW(PW)) u_dly (
                    .CLK     (CLK),
                    .RST_N   (RST_N),
                    .ce_i    (CE),
                    .flush_i (FLUSH),
                    .valid_i (pv[i-1]),
                    .data_i  (pd[i-1]),
                    .valid_o (pv[i]),
                    .data_o  (pd[i])
                );
            end

            assign mul_data  = pd[LAT-2];
            assign mul_valid = pv[LAT-2];
        end
    endgenerate

    logic signed [SW-1:0]      sum, shifted;
    logic signed [BOUND_W-1:0] shifted_ext;
    logic                      ovf_res;
    logic [OUT_WIDTH-1:0]      p_res;

    always_comb begin
        sum         = $signed({mul_data[PW-1], mul_data} + RND);
        shifted     = sum >>> FRAC;
        shifted_ext = BOUND_W'(shifted);
        ovf_res     = (shifted_ext > OUT_MAX) || (shifted_ext < OUT_MIN);
        p_res       = shifted[OUT_WIDTH-1:0];
`ifdef MULTI_GEN_SAT_EN
        if (ovf_res) begin
            p_res = shifted_ext[BOUND_W-1] ? OUT_MIN[OUT_WIDTH-1:0]
                                           : OUT_MAX[OUT_WIDTH-1:0];
        end
`endif
    end

    logic [OUT_WIDTH:0] out_data;

    multi_pipe_stage #(.DW(OUT_WIDTH + 1)) u_out (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .ce_i    (CE),
        .flush_i (FLUSH),
        .valid_i (mul_valid),
        .data_i  ({ovf_res, p_res}),
        .valid_o (OUT_VALID),
        .data_o  (out_data)
    );

    assign {OVF, P} = out_data;

endmodule

// File: tb/tb_multi_gen_1.sv
module tb_multi_gen_1;

    localparam int W   = 16;
    localparam int OW  = 16;
    localparam int FB  = 8;
    localparam int LAT = 3;

    logic          CLK      = 1'b0;
    logic          RST_N    = 1'b0;
    logic          CE       = 1'b0;
    logic          FLUSH    = 1'b0;
    logic          IN_VALID = 1'b0;
    logic [W-1:0]  A        = '0;
    logic [W-1:0]  B        = '0;
    logic          OUT_VALID;
    logic [OW-1:0] P;
    logic          OVF;

    multi_gen_1 #(
        .WIDTH     (W),
        .OUT_WIDTH (OW),
        .FRAC_BITS (FB),
        .LATENCY   (LAT)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CE        (CE),
        .FLUSH     (FLUSH),
        .IN_VALID  (IN_VALID),
        .A         (A),
        .B         (B),
        .OUT_VALID (OUT_VALID),
        .P         (P),
        .OVF       (OVF)
    );

    always #5 CLK = ~CLK;

    int tests  = 0;
    int failed = 0;

    // Reference model: in-flight samples with the number of enabled edges
    // each has seen; a sample is presented once it has aged LAT edges.
    typedef struct {
        longint a;
        longint b;
        int     age;
    } item_t;

    item_t         q[$];
    logic          exp_valid = 1'b0;
    logic [OW-1:0] exp_p     = '0;
    logic          exp_ovf   = 1'b0;

    int            cyc = 0;
    logic [OW-1:0] outs[$];
    int            out_cyc[$];

    function automatic void ref_calc(input longint a, input longint b,
                                     output logic [OW-1:0] p, output logic ovf);
        longint sh;
        longint hi;
        longint lo;
        hi  = (longint'(1) << (OW - 1)) - 1;
        lo  = -(longint'(1) << (OW - 1));
        sh  = (a * b + (longint'(1) << (FB - 1))) >>> FB;
        ovf = (sh > hi) || (sh < lo);
        p   = OW'(sh);
`ifdef MULTI_GEN_SAT_EN
        if (ovf) p = (sh > 0) ? OW'(hi) : OW'(lo);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic ce, input logic fl, input logic iv,
                              input logic [W-1:0] a, input logic [W-1:0] b);
        item_t n;
        item_t it;
        if (fl) begin
            q.delete();
            exp_valid = 1'b0;
        end else if (ce) begin
            for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
            if (iv) begin
                n.a   = longint'($signed(a));
                n.b   = longint'($signed(b));
                n.age = 1;
                q.push_back(n);
            end
            exp_valid = 1'b0;
            if (q.size() > 0 && q[0].age >= LAT) begin
                it        = q.pop_front();
                exp_valid = 1'b1;
                ref_calc(it.a, it.b, exp_p, exp_ovf);
            end
        end
    endtask

    task automatic cycle(input logic ce, input logic fl, input logic iv,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        CE = ce; FLUSH = fl; IN_VALID = iv; A = a; B = b;
        @(posedge CLK);
        model_edge(ce, fl, iv, a, b);
        #1;
        cyc++;
        check("out_valid", 32'(OUT_VALID), 32'(exp_valid));
        check("p",         32'(P),         32'(exp_p));
        check("ovf",       32'(OVF),       32'(exp_ovf));
        if (ce && !fl && OUT_VALID) begin
            outs.push_back(P);
            out_cyc.push_back(cyc);
        end
    endtask

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = 16'h7FFF;
            1:       v = 16'h8000;
            2:       v = 16'hFFFF;
            3:       v = 16'h0080;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        logic [W-1:0]  va[5];
        logic [W-1:0]  vb[5];
        logic [OW-1:0] rp;
        logic          ro;

        // Reset state
        RST_N = 1'b0;
        #12;
        check("reset_out_valid", 32'(OUT_VALID), 32'd0);
        check("reset_p",         32'(P),         32'd0);
        check("reset_ovf",       32'(OVF),       32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // 1.0 * 1.5 in Q8
        cycle(1'b1, 1'b0, 1'b1, 16'h0100, 16'h0180);
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        check("basic_valid", 32'(OUT_VALID), 32'd1);
        check("basic_p",     32'(P),         32'h0180);
        check("basic_ovf",   32'(OVF),       32'd0);

        // Positive overflow
        cycle(1'b1, 1'b0, 1'b1, 16'h7FFF, 16'h7FFF);
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        check("ovf_flag", 32'(OVF), 32'd1);
`ifdef MULTI_GEN_SAT_EN
        check("ovf_p", 32'(P), 32'h7FFF);
`else
        check("ovf_p", 32'(P), 32'hFF00);
`endif

        // -0.5 tie rounds up to 0
        cycle(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0080);
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        check("tie_p",   32'(P),   32'h0000);
        check("tie_ovf", 32'(OVF), 32'd0);

        // Five back-to-back samples with a two-cycle stall mid-stream
        for (int k = 0; k < 5; k++) begin
            va[k] = W'($urandom);
            vb[k] = W'($urandom);
        end
        outs.delete(); out_cyc.delete(); cyc = 0;
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1, va[k], vb[k]);
        cycle(1'b0, 1'b0, 1'b1, W'($urandom), W'($urandom));
        cycle(1'b0, 1'b0, 1'b1, W'($urandom), W'($urandom));
        for (int k = 3; k < 5; k++) cycle(1'b1, 1'b0, 1'b1, va[k], vb[k]);
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b0, '0, '0);
        check("stall_count", 32'(outs.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            ref_calc(longint'($signed(va[k])), longint'($signed(vb[k])), rp, ro);
            check("stall_order", (k < outs.size()) ? 32'(outs[k]) : 32'hxxxxxxxx, 32'(rp));
        end
        check("stall_last_cycle", (out_cyc.size() == 5) ? 32'(out_cyc[4]) : 32'hFFFFFFFF, 32'd9);

        // Flush one cycle after two inputs, then one normal sample
        for (int k = 0; k < 4; k++) begin
            va[k] = W'($urandom);
            vb[k] = W'($urandom);
        end
        outs.delete(); out_cyc.delete(); cyc = 0;
        cycle(1'b1, 1'b0, 1'b1, va[0], vb[0]);
        cycle(1'b1, 1'b0, 1'b1, va[1], vb[1]);
        cycle(1'b1, 1'b1, 1'b1, va[2], vb[2]);
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, 1'b1, va[3], vb[3]);
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b0, '0, '0);
        check("flush_count", 32'(outs.size()), 32'd1);
        ref_calc(longint'($signed(va[3])), longint'($signed(vb[3])), rp, ro);
        check("flush_next_p", (outs.size() > 0) ? 32'(outs[0]) : 32'hxxxxxxxx, 32'(rp));
        check("flush_next_cycle", (out_cyc.size() > 0) ? 32'(out_cyc[0]) : 32'hFFFFFFFF, 32'd7);

        // Reset mid-operation with samples in flight
        cycle(1'b1, 1'b0, 1'b1, 16'h0300, 16'h0200);
        cycle(1'b1, 1'b0, 1'b1, 16'h1234, 16'h0042);
        cycle(1'b1, 1'b0, 1'b1, 16'h8001, 16'h0101);
        check("pre_reset_valid", 32'(OUT_VALID), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        check("midreset_valid", 32'(OUT_VALID), 32'd0);
        check("midreset_p",     32'(P),         32'd0);
        check("midreset_ovf",   32'(OVF),       32'd0);
        q.delete();
        exp_valid = 1'b0; exp_p = '0; exp_ovf = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        outs.delete(); out_cyc.delete();
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 1'b0, '0, '0);
        check("post_reset_stale", 32'(outs.size()), 32'd0);

        // Randomized traffic with stalls and occasional flushes
        for (int k = 0; k < 500; k++) begin
            cycle(($urandom_range(0, 4) != 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 3) != 0), rnd_op(), rnd_op());
        end
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
